// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm
// Direct-mapped, read-only instruction cache with one-word blocks.
// Sits between the datapath fetch port and the memory controller's
// instruction port. Hits answer in the same cycle. A miss issues a
// single-word read, fills the frame, and then the access hits in IDLE on
// the following cycle.
//
// Parameters
//   SETS      number of frames (power of 2)
//   CNT_W     width of the saturating hit / miss counters
//
// Ports
//   CLK       clock, rising edge
//   RST       synchronous active-high reset
//   imemREN   datapath fetch request
//   imemaddr  fetch address (word aligned, bits [1:0] ignored)
//   ihit      imemload is valid this cycle
//   imemload  instruction word returned to the datapath
//   iREN      memory read request
//   iaddr     memory read address
//   iwait     memory busy; iload is valid when iREN=1 and iwait=0
//   iload     memory read data
//   hit_cnt   saturating count of hits
//   miss_cnt  saturating count of misses
// ---------------------------------------------------------------------------
module icache_dm #(
    parameter int SETS  = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 30 - INDEX_W;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Only the word address of the missing fetch is kept; byte offset is
    // irrelevant to a word-aligned memory read.
    logic [31:2]      miss_addr_q, miss_addr_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [SETS-1:0]  valid_q, valid_d;

    // Tag and data arrays need no reset: a frame is only read through its
    // valid bit, which is cleared on reset.
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic               match;
    logic               fill_en;

    // The two low address bits never select anything in a word cache.
    logic unused_addr_bits;
    assign unused_addr_bits = ^imemaddr[1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    assign req_index  = imemaddr[2+INDEX_W-1:2];
    assign req_tag    = imemaddr[31:2+INDEX_W];
    assign fill_index = miss_addr_q[2+INDEX_W-1:2];
    assign fill_tag   = miss_addr_q[31:2+INDEX_W];

    // A hit can only happen in IDLE; during a fill the frame contents are
    // not trusted and the request is re-evaluated once back in IDLE.
    assign match = (state_q == IDLE) && imemREN && valid_q[req_index]
                   && (tag_q[req_index] == req_tag);

    assign ihit     = match;
    assign imemload = data_q[req_index];
    assign iREN     = (state_q == MISS);
    assign iaddr    = (state_q == MISS) ? {miss_addr_q, 2'b00} : 32'h0;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Next-state logic. A fill always completes to the latched miss
    // address, regardless of what the datapath does with imemaddr or
    // imemREN in the meantime, because the memory read cannot be aborted.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        valid_d     = valid_q;
        fill_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (match) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                end else if (imemREN) begin
                    miss_addr_d = imemaddr[31:2];
                    miss_cnt_d  = sat_inc(miss_cnt_q);
                    state_d     = MISS;
                end
            end
            MISS: begin
                if (!iwait) begin
                    fill_en             = 1'b1;
                    valid_d[fill_index] = 1'b1;
                    state_d             = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and counters. Reset abandons any fill in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
        end
    end

    // Frame write on the fill cycle; overwrites unconditionally since the
    // cache is read-only and has nothing to write back.
    always_ff @(posedge CLK) begin
        if (fill_en && !RST) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
`timescale 1ns/1ps

module tb_icache_dm;

   // Main instance signals (default parameters)
   logic        CLK = 1'b0;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   // Saturation instance signals (CNT_W = 4)
   logic        sRst;
   logic        sRen;
   logic [31:0] sAddr;
   logic        sIhit;
   logic [31:0] sLoad;
   logic        sIren;
   logic [31:0] sIaddr;
   logic        sIwait;
   logic [31:0] sIload;
   logic [3:0]  sHitCnt;
   logic [3:0]  sMissCnt;

   int vectorsApplied = 0;
   int miscompares = 0;

   localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

   icache_dm dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   icache_dm #(.SETS(16), .CNT_W(4)) dutSat (
      .CLK(CLK), .RST(sRst), .imemREN(sRen), .imemaddr(sAddr),
      .ihit(sIhit), .imemload(sLoad), .iREN(sIren), .iaddr(sIaddr),
      .iwait(sIwait), .iload(sIload), .hit_cnt(sHitCnt), .miss_cnt(sMissCnt)
   );

   // Free-running clock, 10 ns period
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst;
      logic        ren;
      logic [31:0] addr;
      logic        wait_;
      logic [31:0] load;
      logic        expHit;
      logic        expRen;
      logic [31:0] expAddr;
      logic        chkLoad;
      logic [31:0] expLoad;
      int          expHitCnt;
      int          expMissCnt;
   } vec_t;

   vec_t vecs[$];

   // Memory model: distinct word per address, except 0x40 which carries DEAD
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h40) return DEAD;
      return 32'hC0DE_0000 | {16'h0, a[15:0]};
   endfunction

   function automatic void add(input logic rst, input logic ren, input logic [31:0] addr,
                               input logic wait_, input logic [31:0] load,
                               input logic eh, input logic er, input logic [31:0] ea,
                               input logic cl, input logic [31:0] el,
                               input int hc, input int mc);
      vec_t v;
      v.rst = rst; v.ren = ren; v.addr = addr; v.wait_ = wait_; v.load = load;
      v.expHit = eh; v.expRen = er; v.expAddr = ea; v.chkLoad = cl; v.expLoad = el;
      v.expHitCnt = hc; v.expMissCnt = mc;
      vecs.push_back(v);
   endfunction

   // Compares one observed value against its expectation
   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   // Drives one vector, checks outputs mid-cycle, then clocks it in
   task automatic applyStimulus(input vec_t v, input int idx);
      RST = v.rst; imemREN = v.ren; imemaddr = v.addr; iwait = v.wait_; iload = v.load;
      #2;
      vectorsApplied++;
      checkOutput("ihit", idx, {31'h0, ihit}, {31'h0, v.expHit});
      checkOutput("iREN", idx, {31'h0, iREN}, {31'h0, v.expRen});
      checkOutput("iaddr", idx, iaddr, v.expAddr);
      if (v.chkLoad) checkOutput("imemload", idx, imemload, v.expLoad);
      checkOutput("hit_cnt", idx, {16'h0, hit_cnt}, v.expHitCnt);
      checkOutput("miss_cnt", idx, {16'h0, miss_cnt}, v.expMissCnt);
      @(posedge CLK); #1;
   endtask

   initial begin
      logic [31:0] m80, m100, m200, m44;
      m80 = memWord(32'h80); m100 = memWord(32'h100);
      m200 = memWord(32'h200); m44 = memWord(32'h44);

      // Cold miss on 0x40 with three wait cycles; reset state checked first
      add(0,1,32'h40,1,32'h0,   0,0,32'h0, 0,0, 0,0);
      add(0,1,32'h40,1,32'h0,   0,1,32'h40,0,0, 0,1);
      add(0,1,32'h40,1,32'h0,   0,1,32'h40,0,0, 0,1);
      add(0,1,32'h40,1,32'h0,   0,1,32'h40,0,0, 0,1);
      add(0,1,32'h40,0,DEAD,    0,1,32'h40,0,0, 0,1);
      add(0,1,32'h40,0,32'h0,   1,0,32'h0, 1,DEAD, 0,1);
      // Hit stream: ten more hits on 0x40
      for (int i = 1; i <= 10; i++)
         add(0,1,32'h40,0,32'h0, 1,0,32'h0, 1,DEAD, i,1);
      // Conflict: 0x80 evicts 0x40, then 0x40 evicts 0x80
      add(0,1,32'h80,0,m80,     0,0,32'h0, 0,0, 11,1);
      add(0,1,32'h80,0,m80,     0,1,32'h80,0,0, 11,2);
      add(0,1,32'h80,0,32'h0,   1,0,32'h0, 1,m80, 11,2);
      add(0,1,32'h40,0,DEAD,    0,0,32'h0, 0,0, 12,2);
      add(0,1,32'h40,0,DEAD,    0,1,32'h40,0,0, 12,3);
      add(0,1,32'h40,0,32'h0,   1,0,32'h0, 1,DEAD, 12,3);
      // Redirect mid-miss: 0x100 fill completes, then 0x200 misses
      add(0,1,32'h100,1,32'h0,  0,0,32'h0, 0,0, 13,3);
      add(0,1,32'h200,1,32'h0,  0,1,32'h100,0,0, 13,4);
      add(0,1,32'h200,0,m100,   0,1,32'h100,0,0, 13,4);
      add(0,1,32'h200,0,32'h0,  0,0,32'h0, 0,0, 13,4);
      add(0,0,32'h100,0,m200,   0,1,32'h200,0,0, 13,5);
      add(0,1,32'h200,0,32'h0,  1,0,32'h0, 1,m200, 13,5);
      // Reset mid-miss: previously filled 0x200 must miss afterwards
      add(0,1,32'h40,1,32'h0,   0,0,32'h0, 0,0, 14,5);
      add(1,1,32'h40,1,32'h0,   0,1,32'h40,0,0, 14,6);
      add(0,1,32'h200,1,32'h0,  0,0,32'h0, 0,0, 0,0);
      add(0,1,32'h200,0,m200,   0,1,32'h200,0,0, 0,1);
      add(0,1,32'h200,0,32'h0,  1,0,32'h0, 1,m200, 0,1);
      // Idle fetch port leaves counters alone
      add(0,0,32'h0,0,32'h0,    0,0,32'h0, 0,0, 1,1);
      add(0,0,32'h200,0,32'h0,  0,0,32'h0, 0,0, 1,1);
      // Non-zero index frame
      add(0,1,32'h44,0,m44,     0,0,32'h0, 0,0, 1,1);
      add(0,1,32'h44,0,m44,     0,1,32'h44,0,0, 1,2);
      add(0,1,32'h44,0,32'h0,   1,0,32'h0, 1,m44, 1,2);
      add(0,1,32'h200,0,32'h0,  1,0,32'h0, 1,m200, 2,2);

      RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
      sRst = 1'b1; sRen = 1'b0; sAddr = 32'h0; sIwait = 1'b0; sIload = 32'h0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b0;
      sRst = 1'b0;

      foreach (vecs[i]) applyStimulus(vecs[i], i);

      // Saturation on the narrow-counter instance: one miss, then 20 hits
      sRen = 1'b1; sAddr = 32'h40; sIwait = 1'b0; sIload = 32'h1357_9BDF;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      for (int k = 0; k < 20; k++) begin
         #1;
         vectorsApplied++;
         checkOutput("sat_ihit", 100 + k, {31'h0, sIhit}, 32'h1);
         checkOutput("sat_hit_cnt", 100 + k, {28'h0, sHitCnt}, (k < 15) ? k : 15);
         @(posedge CLK); #1;
      end
      sRen = 1'b0;
      #1;
      vectorsApplied++;
      checkOutput("sat_hit_cnt_final", 200, {28'h0, sHitCnt}, 32'd15);
      checkOutput("sat_miss_cnt", 200, {28'h0, sMissCnt}, 32'd1);
      @(posedge CLK); #1;
      vectorsApplied++;
      checkOutput("sat_hit_cnt_hold", 201, {28'h0, sHitCnt}, 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
